// File: rtl/wam_pkg.sv
// Shared types and constants for the score display controller.
package wam_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam int unsigned BCD_W    = 4;
    localparam logic [3:0]  ERR_CODE = 4'hF;

    // Largest value representable with n decimal digits (10^n - 1).
    function automatic longint unsigned pow10_minus1(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    // Number of decimal digits needed for 2^bw - 1.
    function automatic int unsigned dec_digits(input int unsigned bw);
        longint unsigned m;
        int unsigned     d;
        m = (64'd1 << bw) - 64'd1;
        d = 1;
        while (m >= 64'd10) begin
            m = m / 64'd10;
            d = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble nibble correction: add 3 when the nibble is 5 or more.
module bcd_adj3
    import wam_pkg::*;
(
    input  logic [BCD_W-1:0] nib_i,
    output logic [BCD_W-1:0] nib_o
);

    // Pre-shift correction so the doubled nibble carries correctly into decimal.
    always_comb begin
        nib_o = nib_i;
        if (nib_i >= 4'd5) begin
            nib_o = nib_i + 4'd3;
        end
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Binary score to BCD converter driving the per-digit 7-segment decoders,
// with leading-zero blanking and an all-"E" overflow pattern.
module score_display_ctrl
    import wam_pkg::*;
#(
    parameter int unsigned BIN_WIDTH = 10,
    parameter int unsigned DIGITS    = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [BIN_WIDTH-1:0]    value,
    input  logic                    load,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [4*DIGITS-1:0]     digits,
    output logic [DIGITS-1:0]       digit_en
);

    localparam longint unsigned MAX_VAL = pow10_minus1(DIGITS);
    // Accumulator is wide enough for the full BCD form of 2^BIN_WIDTH-1.
    localparam int unsigned ACC_DIGITS =
        (dec_digits(BIN_WIDTH) > DIGITS) ? dec_digits(BIN_WIDTH) : DIGITS;
    localparam int unsigned ACC_W = BCD_W * ACC_DIGITS;
    localparam int unsigned OUT_W = BCD_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

    state_t                 state_q, state_d;
    logic [BIN_WIDTH-1:0]   shreg_q, shreg_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_pend_q, ovf_pend_d;
    logic                   done_q, done_d;
    logic                   overflow_q, overflow_d;
    logic [OUT_W-1:0]       digits_q, digits_d;
    logic [DIGITS-1:0]      digit_en_q, digit_en_d;

    logic [ACC_W-1:0]           acc_adj;
    logic [ACC_W+BIN_WIDTH-1:0] shifted;
    logic [DIGITS-1:0]          blank_en;
    logic                       lz_seen;

    for (genvar g = 0; g < ACC_DIGITS; g++) begin : g_adj
        bcd_adj3 u_adj (
            .nib_i (acc_q[g*BCD_W +: BCD_W]),
            .nib_o (acc_adj[g*BCD_W +: BCD_W])
        );
    end

    // One double-dabble step: corrected accumulator and shift register move left together.
    always_comb begin
        shifted = {acc_adj, shreg_q} << 1;
    end

    // Enable a digit when it or any more significant digit is nonzero; ones digit always on.
    always_comb begin
        blank_en = '0;
        lz_seen  = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            lz_seen = lz_seen | (|acc_q[(DIGITS-1-i)*BCD_W +: BCD_W]);
            blank_en[DIGITS-1-i] = lz_seen;
        end
        blank_en[0] = 1'b1;
    end

    // Next-state and datapath control; display outputs only update when leaving DONE.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        acc_d      = acc_q;
        count_d    = count_q;
        ovf_pend_d = ovf_pend_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        digits_d   = digits_q;
        digit_en_d = digit_en_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d    = value;
                    acc_d      = '0;
                    count_d    = '0;
                    ovf_pend_d = (64'(value) > MAX_VAL);
                    state_d    = CONV;
                end
            end
            CONV: begin
                acc_d   = shifted[ACC_W+BIN_WIDTH-1:BIN_WIDTH];
                shreg_d = shifted[BIN_WIDTH-1:0];
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(BIN_WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d     = 1'b1;
                overflow_d = ovf_pend_q;
                if (ovf_pend_q) begin
                    digits_d   = {DIGITS{ERR_CODE}};
                    digit_en_d = '1;
                end else begin
                    digits_d   = acc_q[OUT_W-1:0];
                    digit_en_d = blank_en;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            ovf_pend_q <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            digits_q   <= '0;
            digit_en_q <= DIGITS'(1);
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            ovf_pend_q <= ovf_pend_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            digits_q   <= digits_d;
            digit_en_q <= digit_en_d;
        end
    end

    assign busy     = (state_q == CONV);
    assign done     = done_q;
    assign overflow = overflow_q;
    assign digits   = digits_q;
    assign digit_en = digit_en_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed and random checks of score_display_ctrl against a decimal reference model.
module tb_score_display_ctrl;

    logic        clock;
    logic        reset;
    logic [9:0]  value;
    logic        load;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [11:0] digits;
    logic [2:0]  digit_en;

    int n_checks;
    int n_fail;

    // Currently displayed (expected) outputs.
    logic [11:0] cur_digits;
    logic [2:0]  cur_en;
    logic        cur_ovf;

    score_display_ctrl #(
        .BIN_WIDTH (10),
        .DIGITS    (3)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .digits   (digits),
        .digit_en (digit_en)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits by division, digit i shown when v >= 10^i.
    task automatic model(input int v, output logic [11:0] d, output logic [2:0] en,
                         output logic o);
        int t;
        int p;
        o = (v > 999);
        d = '0;
        en = '0;
        if (o) begin
            d  = 12'hFFF;
            en = 3'b111;
        end else begin
            t = v;
            p = 1;
            for (int i = 0; i < 3; i++) begin
                d[4*i +: 4] = 4'(t % 10);
                t = t / 10;
                en[i] = (i == 0) || (v >= p);
                p = p * 10;
            end
        end
    endtask

    // Load v, watch the whole conversion; optionally pulse a stray load at step inj.
    task automatic convert(input int v, input int inj);
        logic [11:0] ed;
        logic [2:0]  ee;
        logic        eo;
        model(v, ed, ee, eo);
        @(negedge clock);
        value = 10'(v);
        load  = 1'b1;
        @(posedge clock);
        #1;
        load  = 1'b0;
        value = 10'($urandom);
        for (int s = 0; s < 10; s++) begin
            chk($sformatf("busy_s%0d", s), 32'(busy), 32'd1);
            chk($sformatf("nodone_s%0d", s), 32'(done), 32'd0);
            chk($sformatf("hold_s%0d", s), 32'(digits), 32'(cur_digits));
            load = (s == inj);
            if (s == inj) value = 10'd123;
            @(posedge clock);
            #1;
            load = 1'b0;
        end
        chk("busy_done_state", 32'(busy), 32'd0);
        chk("done_not_yet", 32'(done), 32'd0);
        chk("hold_done_state", 32'(digits), 32'(cur_digits));
        @(posedge clock);
        #1;
        chk("done_pulse", 32'(done), 32'd1);
        chk("digits", 32'(digits), 32'(ed));
        chk("digit_en", 32'(digit_en), 32'(ee));
        chk("overflow", 32'(overflow), 32'(eo));
        @(posedge clock);
        #1;
        chk("done_single", 32'(done), 32'd0);
        chk("idle_after", 32'(busy), 32'd0);
        cur_digits = ed;
        cur_en     = ee;
        cur_ovf    = eo;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        load  = 1'b0;
        value = '0;
        cur_digits = '0;
        cur_en     = 3'b001;
        cur_ovf    = 1'b0;

        #22;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_digits", 32'(digits), 32'd0);
        chk("rst_en", 32'(digit_en), 32'd1);
        @(negedge clock);
        reset = 1'b1;

        convert(0, -1);
        convert(937, -1);
        convert(42, -1);
        convert(1000, -1);
        convert(5, -1);
        convert(500, 4);

        // Abort a conversion of 999 at step 6 with an asynchronous reset.
        @(negedge clock);
        value = 10'd999;
        load  = 1'b1;
        @(posedge clock);
        #1;
        load = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        chk("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_digits", 32'(digits), 32'd0);
        chk("abort_en", 32'(digit_en), 32'd1);
        chk("abort_ovf", 32'(overflow), 32'd0);
        for (int c = 0; c < 8; c++) begin
            @(posedge clock);
            #1;
            chk("abort_nodone", 32'(done), 32'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock);
            #1;
            chk("abort_idle_nodone", 32'(done), 32'd0);
        end
        cur_digits = '0;
        cur_en     = 3'b001;
        cur_ovf    = 1'b0;
        convert(999, -1);

        for (int r = 0; r < 20; r++) begin
            convert(int'($urandom_range(0, 1023)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #1000000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
